// File: rtl/cs_sched.sv
// cs_sched: round-robin scheduler that time-shares one 9-sample CS filter
// datapath between two 8-bit sample streams. Each channel keeps its own
// sliding window and fill count. Results come back after DP_LAT cycles and
// are tagged with their channel.
module cs_sched #(
    parameter int DP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  s_valid,
    input  logic [7:0]  s_data0,
    input  logic [7:0]  s_data1,
    output logic [1:0]  s_ready,
    input  logic [1:0]  ch_clr,
    output logic        dp_go,
    output logic [71:0] dp_win,
    input  logic [9:0]  dp_y,
    output logic [9:0]  Y,
    output logic        y_valid,
    output logic        y_ch
);

    logic              rr;
    logic [3:0]        cnt     [2];
    logic [71:0]       win     [2];
    logic [3:0]        cnt_nxt [2];
    logic [71:0]       win_nxt [2];
    logic [1:0]        accept;
    logic              issue;
    logic              issue_ch;
    logic              dp_ch;
    logic [DP_LAT-1:0] tag_v;
    logic [DP_LAT-1:0] tag_c;

    // Round-robin grant: a lone requester wins, a tie goes to channel rr
    always_comb begin
        s_ready = '0;
        case (s_valid)
            2'b01:   s_ready = 2'b01;
            2'b10:   s_ready = 2'b10;
            2'b11:   s_ready = rr ? 2'b10 : 2'b01;
            default: s_ready = '0;
        endcase
    end

    assign accept = s_valid & s_ready;

    // Next window and fill count per channel; a flush takes effect before the
    // same-cycle accept, so that accept becomes the first sample of a new fill
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            logic [3:0] base;
            logic [7:0] data;
            base = ch_clr[c] ? 4'd0 : cnt[c];
            data = (c == 0) ? s_data0 : s_data1;
            cnt_nxt[c] = base;
            win_nxt[c] = win[c];
            if (accept[c]) begin
                cnt_nxt[c] = (base == 4'd9) ? 4'd9 : base + 4'd1;
                win_nxt[c] = {data, win[c][71:8]};
            end
        end
        issue    = (accept[0] && cnt_nxt[0] == 4'd9) ||
                   (accept[1] && cnt_nxt[1] == 4'd9);
        issue_ch = accept[1];
    end

    // Channel state: arbitration pointer, windows and fill counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
            for (int unsigned c = 0; c < 2; c++) begin
                cnt[c] <= '0;
                win[c] <= '0;
            end
        end else begin
            if (accept[0]) rr <= 1'b1;
            if (accept[1]) rr <= 1'b0;
            for (int unsigned c = 0; c < 2; c++) begin
                cnt[c] <= cnt_nxt[c];
                win[c] <= win_nxt[c];
            end
        end
    end

    // Issue stage: registered request carrying the post-accept window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_go  <= 1'b0;
            dp_win <= '0;
            dp_ch  <= 1'b0;
        end else begin
            dp_go <= issue;
            if (issue) begin
                dp_win <= issue_ch ? win_nxt[1] : win_nxt[0];
                dp_ch  <= issue_ch;
            end
        end
    end

    // Return stage: tag shift register aligned with the datapath latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v   <= '0;
            tag_c   <= '0;
            Y       <= '0;
            y_valid <= 1'b0;
            y_ch    <= 1'b0;
        end else begin
            tag_v[0] <= dp_go;
            tag_c[0] <= dp_ch;
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_c[i] <= tag_c[i-1];
            end
            y_valid <= tag_v[DP_LAT-1];
            if (tag_v[DP_LAT-1]) begin
                Y    <= dp_y;
                y_ch <= tag_c[DP_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_cs_sched.sv
// Bench for cs_sched: two instances (DP_LAT=1 and DP_LAT=3) share stimulus.
// A behavioural model (arrays of samples, counts, result queues) predicts
// grants, issues and tagged results cycle by cycle.
module tb_cs_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  s_valid = '0;
    logic [1:0]  ch_clr = '0;
    logic [7:0]  s_data0 = '0;
    logic [7:0]  s_data1 = '0;

    logic [1:0]  ready_a, ready_b;
    logic        go_a, go_b;
    logic [71:0] win_a, win_b;
    logic [9:0]  dpy_a, dpy_b;
    logic [9:0]  y_a, y_b;
    logic        yv_a, yv_b;
    logic        ych_a, ych_b;

    always #5 clk = ~clk;

    cs_sched #(.DP_LAT(1)) u_a (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data0(s_data0),
        .s_data1(s_data1), .s_ready(ready_a), .ch_clr(ch_clr), .dp_go(go_a),
        .dp_win(win_a), .dp_y(dpy_a), .Y(y_a), .y_valid(yv_a), .y_ch(ych_a)
    );

    cs_sched #(.DP_LAT(3)) u_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data0(s_data0),
        .s_data1(s_data1), .s_ready(ready_b), .ch_clr(ch_clr), .dp_go(go_b),
        .dp_win(win_b), .dp_y(dpy_b), .Y(y_b), .y_valid(yv_b), .y_ch(ych_b)
    );

    // Datapath stand-in: result = 10 * newest sample; junk when not requested
    function automatic logic [9:0] fdp(input logic [71:0] w);
        logic [13:0] t;
        t = 14'(w[71:64]) * 14'd10;
        return t[9:0];
    endfunction

    logic [9:0] pa;
    logic [9:0] pb [3];
    always @(posedge clk) begin
        pa    <= go_a ? fdp(win_a) : 10'($urandom);
        pb[0] <= go_b ? fdp(win_b) : 10'($urandom);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign dpy_a = pa;
    assign dpy_b = pb[2];

    // Reference model state
    typedef struct {
        int         due;
        bit         ch;
        logic [9:0] y;
    } res_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          rr_m;
    int          cnt_m [2];
    logic [7:0]  win_m [2][9];
    bit          exp_go;
    logic [71:0] exp_win;
    res_t        rq_a[$];
    res_t        rq_b[$];
    logic [9:0]  ey_a, ey_b;
    bit          ech_a, ech_b;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_m = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cnt_m[c] = 0;
            for (int j = 0; j < 9; j++) win_m[c][j] = '0;
        end
        exp_go  = 1'b0;
        exp_win = '0;
        rq_a.delete();
        rq_b.delete();
        ey_a = '0; ey_b = '0; ech_a = 1'b0; ech_b = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = '0;
        ch_clr  = '0;
        #1;
        model_reset();
        chk("rst_ready_a", ready_a, 2'b00);
        chk("rst_go_a", go_a, 1'b0);
        chk("rst_win_a", win_a, 72'd0);
        chk("rst_y_a", y_a, 10'd0);
        chk("rst_yv_a", yv_a, 1'b0);
        chk("rst_ych_a", ych_a, 1'b0);
        chk("rst_go_b", go_b, 1'b0);
        chk("rst_win_b", win_b, 72'd0);
        chk("rst_yv_b", yv_b, 1'b0);
        chk("rst_y_b", y_b, 10'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic post_check();
        chk("dp_go_a", go_a, exp_go);
        chk("dp_win_a", win_a, exp_win);
        chk("dp_go_b", go_b, exp_go);
        chk("dp_win_b", win_b, exp_win);
        if (rq_a.size() > 0 && rq_a[0].due == cyc) begin
            chk("y_valid_a", yv_a, 1'b1);
            ey_a = rq_a[0].y; ech_a = rq_a[0].ch;
            void'(rq_a.pop_front());
        end else chk("y_valid_a", yv_a, 1'b0);
        chk("Y_a", y_a, ey_a);
        chk("y_ch_a", ych_a, ech_a);
        if (rq_b.size() > 0 && rq_b[0].due == cyc) begin
            chk("y_valid_b", yv_b, 1'b1);
            ey_b = rq_b[0].y; ech_b = rq_b[0].ch;
            void'(rq_b.pop_front());
        end else chk("y_valid_b", yv_b, 1'b0);
        chk("Y_b", y_b, ey_b);
        chk("y_ch_b", ych_b, ech_b);
    endtask

    task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] clr);
        logic [1:0] grant;
        logic [7:0] d [2];
        s_valid = v;
        s_data0 = d0;
        s_data1 = d1;
        ch_clr  = clr;
        d[0] = d0;
        d[1] = d1;
        #1;
        if (v == 2'b11) grant = rr_m ? 2'b10 : 2'b01;
        else            grant = v;
        chk("s_ready_a", ready_a, grant);
        chk("s_ready_b", ready_b, grant);
        @(posedge clk);
        cyc++;
        exp_go = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) cnt_m[c] = 0;
            if (grant[c]) begin
                for (int j = 0; j < 8; j++) win_m[c][j] = win_m[c][j+1];
                win_m[c][8] = d[c];
                if (cnt_m[c] < 9) cnt_m[c]++;
                rr_m = (c == 0);
                if (cnt_m[c] == 9) begin
                    logic [9:0] yv;
                    exp_go = 1'b1;
                    for (int j = 0; j < 9; j++) exp_win[8*j +: 8] = win_m[c][j];
                    yv = 10'((int'(d[c]) * 10) % 1024);
                    rq_a.push_back('{due: cyc + 2, ch: (c == 1), y: yv});
                    rq_b.push_back('{due: cyc + 4, ch: (c == 1), y: yv});
                end
            end
        end
        @(negedge clk);
        post_check();
    endtask

    initial begin
        do_reset();

        // Channel 0 alone, samples 1..9 back to back
        for (int i = 1; i <= 9; i++) step(2'b01, 8'(i), 8'd0, 2'b00);
        for (int i = 0; i < 5; i++) step(2'b00, 8'd0, 8'd0, 2'b00);

        // Both channels valid for 20 cycles: alternating grants, interleaved results
        do_reset();
        for (int i = 0; i < 20; i++) step(2'b11, 8'($urandom), 8'($urandom), 2'b00);

        // Idle with both windows full: no issue, pointer untouched
        for (int i = 0; i < 5; i++) step(2'b00, 8'($urandom), 8'($urandom), 2'b00);
        for (int i = 0; i < 4; i++) step(2'b11, 8'($urandom), 8'($urandom), 2'b00);
        for (int i = 0; i < 5; i++) step(2'b00, 8'd0, 8'd0, 2'b00);

        // Channel 1: full window, then flush together with an accept of 7
        do_reset();
        for (int i = 0; i < 9; i++) step(2'b10, 8'd0, 8'(40 + i), 2'b00);
        step(2'b10, 8'd0, 8'd7, 2'b10);
        for (int i = 0; i < 8; i++) step(2'b10, 8'd0, 8'(60 + i), 2'b00);
        for (int i = 0; i < 5; i++) step(2'b00, 8'd0, 8'd0, 2'b00);

        // Reset with two requests in flight, then refill channel 0
        do_reset();
        for (int i = 0; i < 10; i++) step(2'b01, 8'(100 + i), 8'd0, 2'b00);
        do_reset();
        for (int i = 0; i < 9; i++) step(2'b01, 8'(200 + i), 8'd0, 2'b00);
        for (int i = 0; i < 6; i++) step(2'b00, 8'd0, 8'd0, 2'b00);

        // Random traffic with occasional flushes and one reset midway
        for (int i = 0; i < 400; i++) begin
            logic [1:0] clr;
            clr[0] = ($urandom_range(0, 15) == 0);
            clr[1] = ($urandom_range(0, 15) == 0);
            if (i == 200) do_reset();
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), clr);
        end
        for (int i = 0; i < 6; i++) step(2'b00, 8'd0, 8'd0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
